// File: rtl/ppu_sched.sv
// ppu_sched: runs commands of accumulator vectors through the requant PPU into a credit-guarded output FIFO
module ppu_sched #(
   parameter int ARRAY_COL   = 16,
   parameter int NUM_GRP     = 8,
   parameter int GW          = 3,
   parameter int PPU_LAT     = 1,
   parameter int OFIFO_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [GW-1:0]            cfg_addr,
   input  logic [28:0]              cfg_wdata,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [GW-1:0]            cmd_grp,
   input  logic [15:0]              cmd_len,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [ARRAY_COL*32-1:0]  s_data,
   output logic                     ppu_i_valid,
   output logic [ARRAY_COL*32-1:0]  ppu_i_data,
   output logic [15:0]              ppu_cfg_mult,
   output logic [4:0]               ppu_cfg_shift,
   output logic [7:0]               ppu_cfg_zp,
   input  logic                     ppu_o_valid,
   input  logic [ARRAY_COL*8-1:0]   ppu_o_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [ARRAY_COL*8-1:0]   m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err_ovf
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;
   localparam int AW = OFIFO_DEPTH > 1 ? $clog2(OFIFO_DEPTH) : 1;
   localparam int CW = $clog2(OFIFO_DEPTH + 1);
   localparam int IW = $clog2(OFIFO_DEPTH + PPU_LAT + 1);

   logic [1:0]               state;
   logic [28:0]              tbl [NUM_GRP];
   logic [28:0]              shd;
   logic [15:0]              len_r, issued, received;
   logic [IW-1:0]            inflight;
   logic [CW-1:0]            count;
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [ARRAY_COL*8-1:0]   fifo_d [OFIFO_DEPTH];
   logic                     fifo_l [OFIFO_DEPTH];
   logic                     cmd_acc, s_hs, pop, push, full;

   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign cmd_acc   = cmd_valid & cmd_ready;
   assign s_ready   = state == RUN && int'(count) + int'(inflight) < OFIFO_DEPTH && issued < len_r;
   assign s_hs      = s_valid & s_ready;
   assign m_valid   = count != '0;
   assign m_data    = fifo_d[rd_ptr];
   assign m_last    = fifo_l[rd_ptr];
   assign pop       = m_valid & m_ready;
   assign full      = int'(count) == OFIFO_DEPTH;
   assign push      = ppu_o_valid & (!full | pop);
   assign {ppu_cfg_zp, ppu_cfg_shift, ppu_cfg_mult} = shd;

   // command sequencing and the completion pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state == IDLE  ? (cmd_acc && cmd_len != '0 ? SETUP : IDLE)
                : state == SETUP ? RUN
                : state == RUN   ? (s_hs && issued + 16'd1 == len_r ? DRAIN : RUN)
                : (pop && m_last ? IDLE : DRAIN);
         done  <= (cmd_acc && cmd_len == '0) || (state == DRAIN && pop && m_last);
      end

   // quant config table, writable at any time
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < NUM_GRP; i++) tbl[i] <= 29'd1;
      else if (cfg_we)
         tbl[cfg_addr] <= cfg_wdata;

   // per-command shadow config and progress counters (shadow reads the pre-write entry)
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shd      <= 29'd1;
         len_r    <= '0;
         issued   <= '0;
         received <= '0;
      end else if (cmd_acc) begin
         shd      <= tbl[cmd_grp];
         len_r    <= cmd_len;
         issued   <= '0;
         received <= '0;
      end else begin
         if (s_hs) issued <= issued + 16'd1;
         if (ppu_o_valid) received <= received + 16'd1;
      end

   // registered issue into the PPU and count of results still in its pipe
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ppu_i_valid <= 1'b0;
         ppu_i_data  <= '0;
         inflight    <= '0;
      end else begin
         ppu_i_valid <= s_hs;
         if (s_hs) ppu_i_data <= s_data;
         inflight <= (s_hs && !ppu_o_valid) ? inflight + 1'b1
                   : (!s_hs && ppu_o_valid && inflight != '0) ? inflight - 1'b1
                   : inflight;
      end

   // output FIFO capturing PPU results; a push into a full, non-draining FIFO is dropped and flagged
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_ovf <= 1'b0;
         for (int i = 0; i < OFIFO_DEPTH; i++) begin
            fifo_d[i] <= '0;
            fifo_l[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_d[wr_ptr] <= ppu_o_data;
            fifo_l[wr_ptr] <= received + 16'd1 == len_r;
            wr_ptr <= (wr_ptr == AW'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == AW'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count   <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
         err_ovf <= err_ovf | (ppu_o_valid & !push);
      end
endmodule

// File: tb/tb_ppu_sched.sv
// tb_ppu_sched: random-stimulus bench for ppu_sched with a PPU model and a scoreboard reference
module tb_ppu_sched;
   localparam int AC = 16;
   localparam int DEPTH = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                cfg_we = 1'b0;
   logic [2:0]          cfg_addr = '0;
   logic [28:0]         cfg_wdata = '0;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [2:0]          cmd_grp = '0;
   logic [15:0]         cmd_len = '0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [AC*32-1:0]    s_data = '0;
   logic                ppu_i_valid;
   logic [AC*32-1:0]    ppu_i_data;
   logic [15:0]         ppu_cfg_mult;
   logic [4:0]          ppu_cfg_shift;
   logic [7:0]          ppu_cfg_zp;
   logic                ppu_o_valid;
   logic [AC*8-1:0]     ppu_o_data;
   logic                m_valid;
   logic                m_ready = 1'b0;
   logic [AC*8-1:0]     m_data;
   logic                m_last;
   logic                busy;
   logic                done;
   logic                err_ovf;

   always #5 clk = ~clk;

   ppu_sched dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_grp(cmd_grp), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .ppu_i_valid(ppu_i_valid), .ppu_i_data(ppu_i_data),
      .ppu_cfg_mult(ppu_cfg_mult), .ppu_cfg_shift(ppu_cfg_shift), .ppu_cfg_zp(ppu_cfg_zp),
      .ppu_o_valid(ppu_o_valid), .ppu_o_data(ppu_o_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done), .err_ovf(err_ovf)
   );

   // requant of one lane: signed acc * unsigned mult, arithmetic shift, add signed zp, saturate to int8
   function automatic logic [7:0] rq(input logic [31:0] a, input logic [28:0] c);
      longint p;
      logic signed [7:0] z;
      z = c[28:21];
      p = longint'($signed(a));
      p = p * longint'(c[15:0]);
      p = p >>> c[20:16];
      p = p + longint'(z);
      return p > 127 ? 8'h7f : p < -128 ? 8'h80 : p[7:0];
   endfunction

   function automatic logic [AC*8-1:0] rq_vec(input logic [AC*32-1:0] d, input logic [28:0] c);
      logic [AC*8-1:0] r;
      r = '0;
      for (int i = 0; i < AC; i++) r[i*8 +: 8] = rq(d[i*32 +: 32], c);
      return r;
   endfunction

   // one-cycle-latency PPU
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ppu_o_valid <= 1'b0;
         ppu_o_data  <= '0;
      end else begin
         ppu_o_valid <= ppu_i_valid;
         ppu_o_data  <= rq_vec(ppu_i_data, {ppu_cfg_zp, ppu_cfg_shift, ppu_cfg_mult});
      end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [AC*32-1:0] act, input logic [AC*32-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct packed {logic [AC*8-1:0] d; logic l;} exp_t;
   exp_t             q[$];
   exp_t             e;
   logic [28:0]      tbl_m [8];
   logic [28:0]      cfg_m;
   int               cur_len, acc_cnt, outst, age, hs_total, done_cnt, last_cnt, pop_total;
   bit               busy_m, done_exp, iv_exp, pmv, pmr, pml;
   logic [AC*32-1:0] iv_data;
   logic [AC*8-1:0]  pmd;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) tbl_m[i] = 29'd1;
      cfg_m = 29'd1;
      q.delete();
      busy_m = 0; done_exp = 0; iv_exp = 0; pmv = 0;
      outst = 0; acc_cnt = 0; cur_len = 0; age = 0;
   endtask

   // reference model and per-cycle compare, sampled mid-cycle
   initial begin
      hs_total = 0; done_cnt = 0; last_cnt = 0; pop_total = 0;
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         else begin
            chk("done", done, done_exp);
            chk("ppu_i_valid", ppu_i_valid, iv_exp);
            if (iv_exp) chk("ppu_i_data", ppu_i_data, iv_data);
            chk("busy", busy, busy_m);
            chk("cmd_ready", cmd_ready, !busy_m);
            chk("ppu_cfg", {ppu_cfg_zp, ppu_cfg_shift, ppu_cfg_mult}, cfg_m);
            chk("err_ovf", err_ovf, 0);
            chk("s_ready", s_ready, busy_m && age >= 2 && acc_cnt < cur_len && outst < DEPTH);
            if (pmv && !pmr) chk("m_hold", {m_valid, m_last, m_data}, {1'b1, pml, pmd});
            done_exp = 0;
            iv_exp = s_valid && s_ready;
            iv_data = s_data;
            if (cmd_valid && cmd_ready) begin
               cfg_m = tbl_m[cmd_grp];
               cur_len = cmd_len;
               acc_cnt = 0;
               if (cmd_len == 0) done_exp = 1;
               else begin busy_m = 1; age = 1; end
            end else if (busy_m) age++;
            if (s_valid && s_ready) begin
               acc_cnt++;
               hs_total++;
               outst++;
               q.push_back('{d: rq_vec(s_data, cfg_m), l: (acc_cnt == cur_len)});
            end
            if (m_valid && m_ready) begin
               chk("m_queue_nonempty", q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("m_data", m_data, e.d);
                  chk("m_last", m_last, e.l);
                  if (e.l) begin done_exp = 1; busy_m = 0; end
               end
               outst--;
               pop_total++;
               if (m_last) last_cnt++;
            end
            if (done) done_cnt++;
            if (cfg_we) tbl_m[cfg_addr] = cfg_wdata;
            pmv = m_valid; pmr = m_ready; pml = m_last; pmd = m_data;
         end
      end
   end

   int s_pct = 0;
   int m_pct = 100;

   // random stream-side drivers
   initial forever begin
      @(posedge clk);
      #1;
      s_valid = $urandom_range(0, 99) < s_pct;
      for (int i = 0; i < AC; i++) s_data[i*32 +: 32] = 32'($urandom_range(0, 4000)) - 32'd2000;
      m_ready = $urandom_range(0, 99) < m_pct;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_cfg(input int a, input int zp, input int sh, input int mult);
      cfg_we = 1'b1;
      cfg_addr = 3'(a);
      cfg_wdata = {zp[7:0], sh[4:0], mult[15:0]};
      cyc(1);
      cfg_we = 1'b0;
   endtask

   task automatic start_cmd(input int g, input int len, input bit we, input logic [28:0] wd);
      int t = 0;
      while (!cmd_ready && t < 2000) begin cyc(1); t++; end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_grp = 3'(g); cmd_len = 16'(len);
      cfg_we = we; cfg_addr = 3'(g); cfg_wdata = wd;
      cyc(1);
      cmd_valid = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 3000) begin @(negedge clk); t++; end
      chk("done_timeout", t < 3000, 1);
      cyc(1);
   endtask

   int h0, d0, l0, p0;

   initial begin
      cyc(3);
      chk("rst cmd_ready", cmd_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst m_valid", m_valid, 0);
      chk("rst done", done, 0);
      chk("rst s_ready", s_ready, 0);
      chk("rst ppu_i_valid", ppu_i_valid, 0);
      chk("rst err_ovf", err_ovf, 0);
      chk("rst ppu_cfg", {ppu_cfg_zp, ppu_cfg_shift, ppu_cfg_mult}, 29'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cyc(1);
      chk("model rq 5", rq(32'd5, {8'd3, 5'd4, 16'd256}), 8'h53);
      chk("model rq -7", rq(32'hFFFF_FFF9, {8'd3, 5'd4, 16'd256}), 8'h93);
      chk("model rq sat lo", rq(32'hFFFF_FC18, {8'd3, 5'd4, 16'd256}), 8'h80);
      chk("model rq sat hi", rq(32'd100, {8'd3, 5'd4, 16'd256}), 8'h7f);
      chk("model rq unity", rq(32'hFFFF_FFFB, 29'd1), 8'hfb);
      // T1
      wr_cfg(2, 3, 4, 256);
      s_pct = 100; m_pct = 100;
      d0 = done_cnt; l0 = last_cnt; p0 = pop_total;
      start_cmd(2, 4, 0, '0);
      chk("T1 cfg_mult", ppu_cfg_mult, 256);
      chk("T1 cfg_shift", ppu_cfg_shift, 4);
      chk("T1 cfg_zp", ppu_cfg_zp, 3);
      wait_done();
      cyc(3);
      chk("T1 done count", done_cnt - d0, 1);
      chk("T1 last count", last_cnt - l0, 1);
      chk("T1 results", pop_total - p0, 4);
      chk("T1 drained", m_valid, 0);
      // T2
      m_pct = 0;
      h0 = hs_total; p0 = pop_total;
      start_cmd(1, 8, 0, '0);
      cyc(10);
      chk("T2 issued while blocked", hs_total - h0, 2);
      chk("T2 s_ready", s_ready, 0);
      m_pct = 100;
      wait_done();
      chk("T2 results", pop_total - p0, 8);
      // T3
      h0 = hs_total; d0 = done_cnt;
      start_cmd(5, 0, 0, '0);
      wait_done();
      cyc(2);
      chk("T3 no issue", hs_total - h0, 0);
      chk("T3 done count", done_cnt - d0, 1);
      // T4
      s_pct = 50; m_pct = 50;
      start_cmd(2, 6, 0, '0);
      cyc(2);
      wr_cfg(2, 3, 4, 999);
      chk("T4 mult held", ppu_cfg_mult, 256);
      wait_done();
      chk("T4 mult after run", ppu_cfg_mult, 256);
      start_cmd(2, 2, 0, '0);
      chk("T4 mult next cmd", ppu_cfg_mult, 999);
      wait_done();
      start_cmd(3, 3, 1, {8'd0, 5'd0, 16'd77});
      chk("T4 same-cycle old entry", ppu_cfg_mult, 1);
      wait_done();
      start_cmd(3, 1, 0, '0);
      chk("T4 same-cycle new entry", ppu_cfg_mult, 77);
      wait_done();
      // T5
      wr_cfg(4, -6, 7, 40000);
      l0 = last_cnt; p0 = pop_total;
      start_cmd(4, 100, 0, '0);
      wait_done();
      cyc(2);
      chk("T5 last count", last_cnt - l0, 1);
      chk("T5 results", pop_total - p0, 100);
      chk("T5 scoreboard empty", q.size(), 0);
      // T6
      s_pct = 100; m_pct = 100;
      h0 = hs_total;
      start_cmd(2, 10, 0, '0);
      for (int t = 0; t < 200 && hs_total - h0 < 3; t++) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("T6 m_valid", m_valid, 0);
      chk("T6 busy", busy, 0);
      chk("T6 cmd_ready", cmd_ready, 1);
      chk("T6 s_ready", s_ready, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      cyc(1);
      d0 = done_cnt;
      start_cmd(2, 1, 0, '0);
      chk("T6 table reset", ppu_cfg_mult, 1);
      wait_done();
      cyc(2);
      chk("T6 done count", done_cnt - d0, 1);
      cyc(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
